// File: rtl/rca_seq_pkg.sv
// Shared constants and state encoding for the sliced adder.
package rca_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4_slice.sv
// Combinational 4-bit ripple-carry slice built from full-adder equations.
module adder4_slice
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < SLICE_W; k++) begin
      o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
      w_c[k+1]  = (i_a[k] & i_b[k])
                | (w_c[k] & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_c[SLICE_W];
  end

endmodule

// File: rtl/rca_slice_sequencer.sv
// Wide adder time-multiplexing one 4-bit slice over WIDTH/4 cycles.
// Define RCA_SEQ_SUB_EN to add the in_sub port and A-B support.
module rca_slice_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_ovf;

  logic               w_sub;
  logic               w_last;
  logic [IDX_W+1:0]   w_base;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_sl_sum;
  logic               w_sl_cout;

`ifdef RCA_SEQ_SUB_EN
  assign w_sub = in_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_last = (r_idx == LAST);
  assign w_base = {r_idx, 2'b00};
  assign w_a_sl = r_a[w_base +: SLICE_W];
  assign w_b_sl = r_b[w_base +: SLICE_W];

  adder4_slice u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sl_sum),
    .o_cout (w_sl_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Handshake outputs decode state only, never in_valid/out_ready.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= w_sub ? ~in_b : in_b;
            r_carry <= w_sub | in_cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: SLICE_W] <= w_sl_sum;
          r_carry <= w_sl_cout;
          // MSB carry-in recovered from its sum bit, xor carry-out.
          if (w_last)
            r_ovf <= w_a_sl[SLICE_W-1] ^ w_b_sl[SLICE_W-1]
                   ^ w_sl_sum[SLICE_W-1] ^ w_sl_cout;
          else
            r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_carry;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Self-checking bench for rca_slice_sequencer, WIDTH=16.
module tb_rca_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
  logic        in_sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  rca_slice_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef RCA_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic cin,
                                        input logic sub);
    logic [15:0] bb;
    logic [16:0] t;
    logic        ov;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
    ov = (a[15] == bb[15]) && (t[15] != a[15]);
    return {t[16], ov, t[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output logic [15:0] s, output logic co,
                        output logic ov, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      step();
      g++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef RCA_SEQ_SUB_EN
    in_sub = sub;
`endif
    step();
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_cin = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
    in_sub = 1'($urandom);
`endif
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    s = out_sum;
    co = out_cout;
    ov = out_ovf;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic [17:0] m;
    int          lat;
    int          g;
    logic        sub;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_cout", 32'(out_cout), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    step();

    vq.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vq.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vq.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vq.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vq.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    vq.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef RCA_SEQ_SUB_EN
    vq.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vq.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].a, vq[i].b, vq[i].cin, vq[i].sub, s, co, ov, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vq[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vq[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vq[i].ov));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 4);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      m = model(a, b, cin, sub);
      run_op(a, b, cin, sub, s, co, ov, lat);
      chk($sformatf("rnd%0d_sum", i), 32'(s), 32'(m[15:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(co), 32'(m[17]));
      chk($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(m[16]));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 4);
    end

    // Back-pressure with in_valid held high and fresh operands.
    g = 0;
    while (!in_ready && g < 20) begin
      step();
      g++;
    end
    in_valid = 1'b1;
    in_a = 16'h1234;
    in_b = 16'h4321;
    in_cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    step();
    in_a = 16'hAAAA;
    in_b = 16'h1111;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_lat", 32'(lat), 4);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_sum", i), 32'(out_sum), 32'h5555);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 0);
      chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_post_in_ready", 32'(in_ready), 1);
    chk("bp_post_out_valid", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    chk("bp_next_busy", 32'(busy), 1);
    chk("bp_next_in_ready", 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_next_lat", 32'(lat), 4);
    chk("bp_next_sum", 32'(out_sum), 32'hBBBB);
    chk("bp_next_cout", 32'(out_cout), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while slice 2 is about to be processed.
    in_valid = 1'b1;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    in_cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_out_sum", 32'(out_sum), 0);
    chk("mrst_out_cout", 32'(out_cout), 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    chk("mrst_op_sum", 32'(s), 32'h0100);
    chk("mrst_op_cout", 32'(co), 0);
    chk("mrst_op_ovf", 32'(ov), 0);
    chk("mrst_op_lat", 32'(lat), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_slice_sequencer.md
# rca_slice_sequencer

Multi-cycle wide adder that computes a WIDTH-bit sum by time-multiplexing one 4-bit ripple-carry slice over WIDTH/4 cycles.
- Registers both operands on a valid/ready handshake.
- Walks the slices from least significant to most significant, carrying between them in a register.
- Presents sum, carry-out and signed overflow on a valid/ready output.

It sits between an operand producer and a result consumer wherever a full-width combinational adder costs too much area.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; ignored when in_sub=1
- in_sub  input  1  subtract request; port exists only with RCA_SEQ_SUB_EN
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of bit WIDTH-1
- out_ovf  output  1  signed two's-complement overflow
- busy  output  1  high whenever state ≠ IDLE

## Operation
- SLICES = WIDTH/4. The slice counter idx is clog2(SLICES) bits wide.
- State machine states and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready:
    - capture a_r ← in_a.
    - capture b_r ← in_b, or ~in_b when subtracting.
    - capture carry_r ← in_cin, or 1 when subtracting.
    - idx ← 0; go to RUN.
  - RUN: slice i = idx feeds a_r[4i+3:4i], b_r[4i+3:4i] and carry_r to the 4-bit slice.
    - Writes sum_r[4i+3:4i] and carry_r ← slice cout.
    - On idx = SLICES-1, also latch ovf ← (a_r[W-1] ^ b_r[W-1] ^ slice sum bit 3) ^ slice cout, i.e. carry-in of MSB xor carry-out. Then go to DONE.
    - Otherwise idx ← idx+1.
  - DONE: out_valid=1. out_sum, out_cout and out_ovf are stable and held while out_ready=0. On out_ready go to IDLE.
- in_ready is 0 in RUN and DONE. Operand changes after acceptance have no effect.
- Subtraction result: out_cout=1 means no borrow.
- All arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset behaviour (any cycle, including mid-RUN or in DONE):
  - state ← IDLE; the in-flight operation is discarded.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=1 on the first cycle after the reset edge.
- in_valid is not sampled during reset.

## Timing
- Operand acceptance edge T. RUN occupies edges T+1 … T+SLICES.
- out_valid is high from the cycle after edge T+SLICES. Latency is SLICES cycles, which is 4 for WIDTH=16.
- Minimum initiation interval is SLICES+2 cycles: accept, SLICES RUN cycles, one DONE cycle.
- Result handshake completes on the edge where out_valid && out_ready. in_ready rises in the following cycle.
- All outputs are registered or decoded from state. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- RCA_SEQ_SUB_EN defined:
  - in_sub port present.
  - in_sub=1 inverts B and forces carry-in to 1, computing A−B.
- RCA_SEQ_SUB_EN undefined:
  - in_sub port absent; add only.
  - b_r ← in_b and carry_r ← in_cin always.

## Structure
- Package rca_seq_pkg:
  - SLICE_W = 4.
  - State enum {IDLE, RUN, DONE}, 2-bit encoding.
- Sub-module adder4_slice: combinational 4-bit ripple-carry adder (a, b, cin → sum, cout) built from 1-bit full-adder equations. It is instantiated once; the sequencer holds only control, operand and result registers.

## Test plan
All scenarios use WIDTH=16.
- 0x1234 + 0x4321, cin=0 -> out_sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0. Confirms carry propagates through all four slices.
- 0x7FFF + 0x0001 -> out_sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000 -> 0x0000, cout=1, ovf=1.
- Result back-pressure: out_ready held low 5 cycles in DONE, with in_valid=1 and new operands applied -> out_sum stable, in_ready=0, new operands ignored. The next operation is accepted one cycle after the result handshake.
- With RCA_SEQ_SUB_EN, 0x0005 − 0x0007 -> out_sum=0xFFFE, cout=0 (borrow), ovf=0. Also 0x8000 − 0x0001 -> 0x7FFF, ovf=1.
- rst_n low for one edge while idx=2 -> out_valid=0, busy=0, in_ready=1 next cycle. A following 0x00FF + 0x0001 yields 0x0100 with no residual carry.
